// File: rtl/keccak_absorb_pad.sv
// ---------------------------------------------------------------------------
// keccak_absorb_pad
//
// Sponge absorb front-end for a Keccak-f[1600] round engine. Message words
// arrive over a valid/ready stream and are XORed lane by lane into the rate
// part of the 1600-bit state. SHA-3 multi-rate padding (domain byte at the
// first free byte, 0x80 in the top byte of the last rate lane) is applied
// when the final word arrives. One permutation is launched per full rate
// block, and the final permuted state is presented to the squeeze stage.
//
// Parameters
//   RATE_WORDS  rate in 64-bit lanes (17 = SHA3-256), legal 1..24
//   DOMAIN_PAD  domain/pad-start byte (8'h06 SHA-3, 8'h1F SHAKE)
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high
//   in_data      message word, byte k = in_data[8k+7:8k]
//   in_valid     in_data/in_last/in_bytes valid
//   in_last      final word of the message
//   in_bytes     valid bytes in the final word (0..8, larger values = 8)
//   in_ready     word accepted when in_valid & in_ready
//   perm_start   one-cycle pulse asking the round engine to permute perm_state
//   perm_state   state handed to the round engine, lane i = [64i+63:64i]
//   perm_done    one-cycle pulse from the round engine, perm_result valid
//   perm_result  permuted state
//   out_valid    final absorbed and permuted state available
//   out_state    final state
//   out_ready    downstream accepts out_state when out_valid & out_ready
// ---------------------------------------------------------------------------
module keccak_absorb_pad #(
    parameter int         RATE_WORDS = 17,
    parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   in_data,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          in_ready,
    output logic          perm_start,
    output logic [1599:0] perm_state,
    input  logic          perm_done,
    input  logic [1599:0] perm_result,
    output logic          out_valid,
    output logic [1599:0] out_state,
    input  logic          out_ready
);

    // Lane counter width; a single-lane rate still needs a 1-bit counter.
    localparam int WC_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_LANE = WC_W'(RATE_WORDS - 1);

    // Bit offset of byte 7 of the last rate lane, where the closing 0x80 goes.
    localparam int TOP_PAD_BIT = 64 * (RATE_WORDS - 1) + 56;

    typedef enum logic [2:0] {
        ABSORB,
        PAD,
        START,
        WAIT,
        OUTPUT
    } state_t;

    state_t          state;
    logic [1599:0]   s;
    logic [WC_W-1:0] wcnt;
    logic            fin;
    logic            pad_pend;

    logic [3:0]      nb;
    logic [63:0]     byte_mask;
    logic [1599:0]   s_absorb;
    logic [1599:0]   s_pad;

    assign perm_state = s;
    assign out_state  = s;

    // The stream is only open while absorbing; everywhere else the word is
    // left untouched on the bus.
    assign in_ready = (state == ABSORB);

    // Next-state value of S for an accepted word. The word is XORed into the
    // current lane with the unused tail bytes of a final word cleared. When
    // the final word leaves room, the domain byte lands right after the last
    // message byte. When the final word fills its lane but the block still
    // has lanes left, the domain byte starts the next lane instead. The 0x80
    // is XORed rather than written so it merges with a domain byte that falls
    // in the same position (0x06 ^ 0x80 = 0x86). A final word that fills the
    // last rate lane gets no padding here; the PAD state adds a whole padding
    // block after the permutation.
    always_comb begin
        nb        = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        byte_mask = '0;
        for (int k = 0; k < 8; k++) begin
            byte_mask[8*k +: 8] = (!in_last || (k < int'(nb))) ? 8'hFF : 8'h00;
        end

        s_absorb = s;
        s_absorb[64*int'(wcnt) +: 64] = s[64*int'(wcnt) +: 64] ^ (in_data & byte_mask);
        if (in_last) begin
            if (nb != 4'd8) begin
                s_absorb[64*int'(wcnt) + 8*int'(nb) +: 8] =
                    s_absorb[64*int'(wcnt) + 8*int'(nb) +: 8] ^ DOMAIN_PAD;
                s_absorb[TOP_PAD_BIT +: 8] = s_absorb[TOP_PAD_BIT +: 8] ^ 8'h80;
            end else if (wcnt != LAST_LANE) begin
                s_absorb[64*(int'(wcnt) + 1) +: 8] =
                    s_absorb[64*(int'(wcnt) + 1) +: 8] ^ DOMAIN_PAD;
                s_absorb[TOP_PAD_BIT +: 8] = s_absorb[TOP_PAD_BIT +: 8] ^ 8'h80;
            end
        end

        // Padding-only block, used when the message ended exactly on a block
        // boundary.
        s_pad = s;
        s_pad[7:0] = s[7:0] ^ DOMAIN_PAD;
        s_pad[TOP_PAD_BIT +: 8] = s_pad[TOP_PAD_BIT +: 8] ^ 8'h80;
    end

    // Main FSM. perm_start and out_valid are registered and set on the same
    // edge that enters START / OUTPUT, so they follow the state exactly.
    // fin records that the block in flight is the last one; pad_pend
    // records that a padding-only block still has to follow it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ABSORB;
            s          <= '0;
            wcnt       <= '0;
            fin        <= 1'b0;
            pad_pend   <= 1'b0;
            perm_start <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            perm_start <= 1'b0;
            case (state)
                ABSORB: begin
                    if (in_valid) begin
                        s <= s_absorb;
                        if (!in_last) begin
                            if (wcnt != LAST_LANE) begin
                                wcnt <= wcnt + WC_W'(1);
                            end else begin
                                wcnt       <= '0;
                                fin        <= 1'b0;
                                state      <= START;
                                perm_start <= 1'b1;
                            end
                        end else if ((nb != 4'd8) || (wcnt != LAST_LANE)) begin
                            wcnt       <= '0;
                            fin        <= 1'b1;
                            state      <= START;
                            perm_start <= 1'b1;
                        end else begin
                            wcnt       <= '0;
                            fin        <= 1'b0;
                            pad_pend   <= 1'b1;
                            state      <= START;
                            perm_start <= 1'b1;
                        end
                    end
                end

                PAD: begin
                    s          <= s_pad;
                    fin        <= 1'b1;
                    pad_pend   <= 1'b0;
                    state      <= START;
                    perm_start <= 1'b1;
                end

                START: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (perm_done) begin
                        s <= perm_result;
                        if (fin) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                        end else if (pad_pend) begin
                            state <= PAD;
                        end else begin
                            wcnt  <= '0;
                            state <= ABSORB;
                        end
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        s         <= '0;
                        wcnt      <= '0;
                        fin       <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= ABSORB;
                    end
                end

                default: begin
                    state <= ABSORB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb_pad.sv
// ---------------------------------------------------------------------------
// tb_keccak_absorb_pad
//
// Directed bench for keccak_absorb_pad with the default SHA3-256 parameters
// (17 rate lanes, domain byte 0x06). A stub round engine answers every
// perm_start with perm_done about 24 cycles later, returning the captured
// state XORed with a fixed 0xA5 pattern, and logs every state it was handed.
// Expected states are written out lane by lane in each test.
// ---------------------------------------------------------------------------
module tb_keccak_absorb_pad;

    localparam logic [1599:0] STUB = {25{64'hA5A5A5A5A5A5A5A5}};
    localparam logic [63:0]   TOP80 = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
    logic          in_ready;
    logic          perm_start;
    logic [1599:0] perm_state;
    logic          perm_done;
    logic [1599:0] perm_result;
    logic          out_valid;
    logic [1599:0] out_state;
    logic          out_ready = 1'b0;

    int            total = 0;
    int            bad = 0;
    int            n_starts = 0;
    bit            engine_busy = 1'b0;
    logic [1599:0] perm_log [0:15];

    keccak_absorb_pad dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .in_ready    (in_ready),
        .perm_start  (perm_start),
        .perm_state  (perm_state),
        .perm_done   (perm_done),
        .perm_result (perm_result),
        .out_valid   (out_valid),
        .out_state   (out_state),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Stub round engine: sees perm_start on the falling edge, holds the
    // captured state, and pulses perm_done 23 falling edges later so that
    // the DUT samples it 24 cycles after perm_start rose.
    initial begin : round_engine
        logic [1599:0] captured;
        perm_done   = 1'b0;
        perm_result = '0;
        forever begin
            @(negedge clk);
            perm_done = 1'b0;
            if (perm_start === 1'b1) begin
                captured = perm_state;
                if (n_starts < 16) perm_log[n_starts] = captured;
                n_starts++;
                engine_busy = 1'b1;
                repeat (23) @(negedge clk);
                perm_result = captured ^ STUB;
                perm_done   = 1'b1;
                engine_busy = 1'b0;
            end
        end
    end

    function automatic logic [63:0] pat(input int i);
        return 64'h1111_1111_1111_1111 * 64'(i + 1);
    endfunction

    // Index of the first lane where two states differ, for short FAIL lines.
    function automatic int diff_lane(input logic [1599:0] a, input logic [1599:0] b);
        for (int i = 0; i < 25; i++) begin
            if (a[64*i +: 64] !== b[64*i +: 64]) return i;
        end
        return 0;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nbytes);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        in_data  = d;
        in_last  = last;
        in_bytes = nbytes;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = '0;
        in_data  = '0;
    endtask

    task automatic wait_out();
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_engine_idle();
        int cyc;
        cyc = 0;
        while (engine_busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic accept_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
        end
        total++;
        if (perm_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_perm_start got=%b want=0", perm_start);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_state !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state lane%0d got=%h want=0", diff_lane(out_state, '0),
                     out_state[64*diff_lane(out_state, '0) +: 64]);
        end
    endtask

    task automatic test_empty_msg();
        logic [1599:0] e;
        int base, k;
        base = n_starts;
        e = '0;
        e[7:0] = 8'h06;
        e[64*16 +: 64] = TOP80;
        send_word(64'h0, 1'b1, 4'd0);
        wait_out();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL empty_out_valid got=%b want=1", out_valid);
        end
        total++;
        if (n_starts - base != 1) begin
            bad++;
            $display("[TB] FAIL empty_perm_count got=%0d want=1", n_starts - base);
        end
        total++;
        if (perm_log[base] !== e) begin
            bad++;
            k = diff_lane(perm_log[base], e);
            $display("[TB] FAIL empty_perm_state lane%0d got=%h want=%h", k, perm_log[base][64*k +: 64], e[64*k +: 64]);
        end
        total++;
        if (out_state !== (e ^ STUB)) begin
            bad++;
            k = diff_lane(out_state, e ^ STUB);
            $display("[TB] FAIL empty_out_state lane%0d got=%h want=%h", k, out_state[64*k +: 64], STUB[64*k +: 64] ^ e[64*k +: 64]);
        end
        accept_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL empty_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        if (out_state !== '0) begin
            bad++;
            $display("[TB] FAIL empty_clear lane%0d got=%h want=0", diff_lane(out_state, '0), out_state[64*diff_lane(out_state, '0) +: 64]);
        end
    endtask

    // One byte in a word whose upper bytes carry junk that must be masked;
    // also checks the one-cycle perm_start latency and pulse width.
    task automatic test_one_byte();
        logic [1599:0] e;
        int base, k;
        base = n_starts;
        e = '0;
        e[63:0] = 64'h0000_0000_0000_06AB;
        e[64*16 +: 64] = TOP80;
        @(negedge clk);
        in_data  = 64'hDEAD_BEEF_CAFE_F0AB;
        in_last  = 1'b1;
        in_bytes = 4'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (perm_start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL one_byte_start_latency got=%b want=1", perm_start);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL one_byte_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (perm_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL one_byte_start_width got=%b want=0", perm_start);
        end
        wait_out();
        total++;
        if (n_starts - base != 1) begin
            bad++;
            $display("[TB] FAIL one_byte_perm_count got=%0d want=1", n_starts - base);
        end
        total++;
        if (perm_log[base] !== e) begin
            bad++;
            k = diff_lane(perm_log[base], e);
            $display("[TB] FAIL one_byte_perm_state lane%0d got=%h want=%h", k, perm_log[base][64*k +: 64], e[64*k +: 64]);
        end
        total++;
        if (out_valid !== 1'b1 || out_state !== (e ^ STUB)) begin
            bad++;
            k = diff_lane(out_state, e ^ STUB);
            $display("[TB] FAIL one_byte_out valid=%b lane%0d got=%h want=%h", out_valid, k, out_state[64*k +: 64], STUB[64*k +: 64] ^ e[64*k +: 64]);
        end
        accept_out();
    endtask

    // Final word in the last rate lane with 7 bytes: domain byte and 0x80
    // land in the same byte.
    task automatic test_last_lane_merge();
        logic [1599:0] e;
        int base, k;
        base = n_starts;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            e[64*i +: 64] = pat(i);
            send_word(pat(i), 1'b0, 4'd0);
        end
        e[64*16 +: 64] = 64'h86EE_DDCC_BBAA_9988;
        send_word(64'hFFEE_DDCC_BBAA_9988, 1'b1, 4'd7);
        wait_out();
        total++;
        if (n_starts - base != 1) begin
            bad++;
            $display("[TB] FAIL merge_perm_count got=%0d want=1", n_starts - base);
        end
        total++;
        if (perm_log[base] !== e) begin
            bad++;
            k = diff_lane(perm_log[base], e);
            $display("[TB] FAIL merge_perm_state lane%0d got=%h want=%h", k, perm_log[base][64*k +: 64], e[64*k +: 64]);
        end
        total++;
        if (out_state !== (e ^ STUB)) begin
            bad++;
            k = diff_lane(out_state, e ^ STUB);
            $display("[TB] FAIL merge_out_state lane%0d got=%h want=%h", k, out_state[64*k +: 64], STUB[64*k +: 64] ^ e[64*k +: 64]);
        end
        accept_out();
    endtask

    // 17 full words ending exactly on the block boundary: a padding-only
    // block follows the first permutation.
    task automatic test_full_block_pad();
        logic [1599:0] b1, e2;
        int base, k;
        base = n_starts;
        b1 = '0;
        for (int i = 0; i < 17; i++) begin
            b1[64*i +: 64] = pat(i);
            send_word(pat(i), (i == 16), (i == 16) ? 4'd8 : 4'd0);
        end
        e2 = b1 ^ STUB;
        e2[7:0] = e2[7:0] ^ 8'h06;
        e2[64*16 +: 64] = e2[64*16 +: 64] ^ TOP80;
        wait_out();
        total++;
        if (n_starts - base != 2) begin
            bad++;
            $display("[TB] FAIL fullpad_perm_count got=%0d want=2", n_starts - base);
        end
        total++;
        if (perm_log[base] !== b1) begin
            bad++;
            k = diff_lane(perm_log[base], b1);
            $display("[TB] FAIL fullpad_block1 lane%0d got=%h want=%h", k, perm_log[base][64*k +: 64], b1[64*k +: 64]);
        end
        total++;
        if (perm_log[base+1] !== e2) begin
            bad++;
            k = diff_lane(perm_log[base+1], e2);
            $display("[TB] FAIL fullpad_block2 lane%0d got=%h want=%h", k, perm_log[base+1][64*k +: 64], e2[64*k +: 64]);
        end
        total++;
        if (out_state !== (e2 ^ STUB)) begin
            bad++;
            k = diff_lane(out_state, e2 ^ STUB);
            $display("[TB] FAIL fullpad_out_state lane%0d got=%h want=%h", k, out_state[64*k +: 64], STUB[64*k +: 64] ^ e2[64*k +: 64]);
        end
        accept_out();
    endtask

    // A non-final full block, then a final word at lane 0 with in_bytes=12
    // (treated as 8): the domain byte starts lane 1.
    task automatic test_next_lane_pad();
        logic [1599:0] b1, e2;
        int base, k;
        base = n_starts;
        b1 = '0;
        for (int i = 0; i < 17; i++) begin
            b1[64*i +: 64] = pat(i);
            send_word(pat(i), 1'b0, 4'd0);
        end
        send_word(64'hFEDC_BA98_7654_3210, 1'b1, 4'd12);
        e2 = b1 ^ STUB;
        e2[63:0]   = e2[63:0] ^ 64'hFEDC_BA98_7654_3210;
        e2[71:64]  = e2[71:64] ^ 8'h06;
        e2[64*16 +: 64] = e2[64*16 +: 64] ^ TOP80;
        wait_out();
        total++;
        if (n_starts - base != 2) begin
            bad++;
            $display("[TB] FAIL nextpad_perm_count got=%0d want=2", n_starts - base);
        end
        total++;
        if (perm_log[base] !== b1) begin
            bad++;
            k = diff_lane(perm_log[base], b1);
            $display("[TB] FAIL nextpad_block1 lane%0d got=%h want=%h", k, perm_log[base][64*k +: 64], b1[64*k +: 64]);
        end
        total++;
        if (perm_log[base+1] !== e2) begin
            bad++;
            k = diff_lane(perm_log[base+1], e2);
            $display("[TB] FAIL nextpad_block2 lane%0d got=%h want=%h", k, perm_log[base+1][64*k +: 64], e2[64*k +: 64]);
        end
        accept_out();
    endtask

    // out_ready held low for 10 cycles while junk is offered on the input.
    task automatic test_backpressure();
        logic [1599:0] e;
        int base, k;
        base = n_starts;
        e = '0;
        e[7:0] = 8'h06;
        e[64*16 +: 64] = TOP80;
        send_word(64'h0, 1'b1, 4'd0);
        wait_out();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_data  = 64'h0BAD_0BAD_0BAD_0BAD;
            in_last  = 1'b1;
            in_bytes = 4'd3;
            in_valid = 1'b1;
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL bp_out_valid cycle%0d got=%b want=1", c, out_valid);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_in_ready cycle%0d got=%b want=0", c, in_ready);
            end
            total++;
            if (out_state !== (e ^ STUB)) begin
                bad++;
                k = diff_lane(out_state, e ^ STUB);
                $display("[TB] FAIL bp_out_state cycle%0d lane%0d got=%h want=%h", c, k, out_state[64*k +: 64], STUB[64*k +: 64] ^ e[64*k +: 64]);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = '0;
        in_data  = '0;
        accept_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        if (out_state !== '0) begin
            bad++;
            $display("[TB] FAIL bp_clear lane%0d got=%h want=0", diff_lane(out_state, '0), out_state[64*diff_lane(out_state, '0) +: 64]);
        end
        total++;
        if (n_starts - base != 1) begin
            bad++;
            $display("[TB] FAIL bp_perm_count got=%0d want=1", n_starts - base);
        end
    endtask

    // Reset while the DUT waits on the engine; the engine's late perm_done
    // must then be ignored.
    task automatic test_reset_in_wait();
        int base, cyc;
        base = n_starts;
        send_word(64'h0000_0000_0000_0123, 1'b1, 4'd2);
        cyc = 0;
        while (engine_busy !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (engine_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstwait_no_start got=%b want=1", engine_busy);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || perm_start !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstwait_outputs got in_ready=%b perm_start=%b out_valid=%b want 1/0/0", in_ready, perm_start, out_valid);
        end
        total++;
        if (out_state !== '0) begin
            bad++;
            $display("[TB] FAIL rstwait_state lane%0d got=%h want=0", diff_lane(out_state, '0), out_state[64*diff_lane(out_state, '0) +: 64]);
        end
        wait_engine_idle();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstwait_stray_done got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        if (out_state !== '0) begin
            bad++;
            $display("[TB] FAIL rstwait_stray_state lane%0d got=%h want=0", diff_lane(out_state, '0), out_state[64*diff_lane(out_state, '0) +: 64]);
        end
        total++;
        if (n_starts - base != 1) begin
            bad++;
            $display("[TB] FAIL rstwait_perm_count got=%0d want=1", n_starts - base);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_empty_msg();
        test_one_byte();
        test_last_lane_merge();
        test_full_block_pad();
        test_next_lane_pad();
        test_backpressure();
        test_reset_in_wait();
        // Back-to-back: a fresh message right after the reset recovery.
        test_empty_msg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
